pwm_array_ctrl: RTL

PWM_ARRAY_CTRL -- requirements
Module: pwm_array_ctrl

---
 rtl/pwm_array_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pwm_array_ctrl.sv
// NUM_CH-channel PWM array sharing one prescaled period counter, with shadowed per-channel duty.
// Define PWM_ARRAY_CENTER_ALIGN_EN for an up/down (centre-aligned) counter; edge-aligned otherwise.

module pwm_array_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en_out,
    input  logic             en_pwm,
    output logic             pwm_out
);
    logic [CNT_W-1:0] duty_shadow;
    logic [CNT_W-1:0] duty_active;
    logic             pwm_raw;

    // all-ones duty is forced high so a full-width top can still reach 100 %
    assign pwm_raw = (cnt < duty_active) || (duty_active == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow <= '0;
            duty_active <= '0;
            pwm_out     <= 1'b0;
        end else begin
            if (wr_hit)
                duty_shadow <= wr_data;
            // a write landing on the wrap cycle bypasses the shadow
            if (wrap)
                duty_active <= wr_hit ? wr_data : duty_shadow;
            pwm_out <= en_out & (~en_pwm | pwm_raw);
        end
    end
endmodule

module pwm_array_ctrl #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int CH_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    input  logic              duty_wr,
    input  logic [CH_W-1:0]   duty_ch,
    input  logic [CNT_W-1:0]  duty_data,
    input  logic [CNT_W-1:0]  period_top,
    input  logic [7:0]        prescale_div,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);
    typedef struct packed {
        logic             vld;
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] data;
    } duty_req_t;

    duty_req_t        duty_req;
    logic [7:0]       pre_cnt;
    logic             advance;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] top_active;
    logic             wrap;

    assign duty_req = '{vld: duty_wr, ch: duty_ch, data: duty_data};

    // >= rather than == so shrinking prescale_div below the running count advances at once
    assign advance = (pre_cnt >= prescale_div);

`ifdef PWM_ARRAY_CENTER_ALIGN_EN
    logic cnt_up;
    logic up_nxt;

    always_comb begin
        wrap    = 1'b0;
        cnt_nxt = cnt;
        up_nxt  = cnt_up;
        if (advance) begin
            if (top_active == '0) begin
                wrap    = 1'b1;
                cnt_nxt = '0;
                up_nxt  = 1'b1;
            end else if (cnt_up) begin
                if (cnt >= top_active) begin
                    up_nxt  = 1'b0;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (cnt <= CNT_W'(1)) begin
                wrap    = 1'b1;
                cnt_nxt = '0;
                up_nxt  = 1'b1;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_up <= 1'b1;
        else
            cnt_up <= up_nxt;
    end
`else
    always_comb begin
        wrap    = advance && (cnt >= top_active);
        cnt_nxt = cnt;
        if (wrap)
            cnt_nxt = '0;
        else if (advance)
            cnt_nxt = cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            top_active  <= '1;
            period_tick <= 1'b0;
        end else begin
            pre_cnt     <= advance ? 8'd0 : pre_cnt + 8'd1;
            cnt         <= cnt_nxt;
            period_tick <= wrap;
            if (wrap)
                top_active <= period_top;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        pwm_array_lane #(.CNT_W(CNT_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_hit  (duty_req.vld && (duty_req.ch == CH_W'(i))),
            .wr_data (duty_req.data),
            .wrap    (wrap),
            .cnt     (cnt),
            .en_out  (en_out[i]),
            .en_pwm  (en_pwm[i]),
            .pwm_out (pwm_out[i])
        );
    end
endmodule
